// File: rtl/counter_sched_rr.sv
`default_nettype none
// ============================================================================
// Module   : counter_sched_rr
// Purpose  : Round-robin scheduler that time-shares one up-counter among
//            NREQ requesters. The winner owns the counter from 0 up to its
//            captured terminal count, then gets a one-cycle done pulse.
// Ports    : clk    - sole clock, rising edge
//            reset  - synchronous, active-high
//            req    - per-requester interval request
//            tc     - per-requester terminal count, slice i = tc[i*WIDTH +: WIDTH]
//            abort  - (only with COUNTER_SCHED_ABORT_EN) cancel the active interval
//            gnt    - one-hot owner of the counter, zero when unowned
//            done   - one-cycle completion pulse to the owner
//            busy   - high whenever the scheduler is not idle
//            count  - shared counter value
// Config   : define COUNTER_SCHED_ABORT_EN to add the abort input
// Revision : 1.0 - initial release
// ============================================================================
module counter_sched_rr #(
    parameter int WIDTH = 10,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] tc,
`ifdef COUNTER_SCHED_ABORT_EN
    input  logic                  abort,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count
);

    localparam int c_IDXW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic              r_busy;
    logic [WIDTH-1:0]  r_count;
    logic [WIDTH-1:0]  r_tc_q;
    logic [c_IDXW-1:0] r_ptr;
    logic [c_IDXW-1:0] r_owner;

    logic [WIDTH-1:0]  w_tc_arr [NREQ];
    logic              w_found;
    logic [c_IDXW-1:0] w_win;
    logic [c_IDXW-1:0] w_cand;
    logic [NREQ-1:0]   w_win_oh;
    logic [c_IDXW-1:0] w_next_ptr;
    logic              w_abort;

`ifdef COUNTER_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Unpack the flat terminal-count bus so the winner's slice can be
    // selected with a plain array index.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_tc
        assign w_tc_arr[gi] = tc[gi*WIDTH +: WIDTH];
    end

    // Rotating priority search starting at r_ptr. The loop walks from the
    // farthest candidate back to r_ptr so the last hit written is the
    // nearest one in round-robin order.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = c_IDXW'((int'(r_ptr) + k) % NREQ);
            if (req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_next_ptr = (r_owner == c_IDXW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_tc_q  <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // count is deliberately left at its last value while idle
                    if (w_found) begin
                        r_state <= S_COUNT;
                        r_owner <= w_win;
                        r_gnt   <= w_win_oh;
                        r_count <= '0;
                        r_tc_q  <= w_tc_arr[w_win];
                        r_busy  <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                        r_count <= '0;
                        r_ptr   <= w_next_ptr;
                        r_busy  <= 1'b0;
                    end else if (r_count == r_tc_q) begin
                        r_state <= S_DONE;
                        r_gnt   <= '0;
                        r_done  <= r_gnt;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= '0;
                    r_ptr   <= w_next_ptr;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign busy  = r_busy;
    assign count = r_count;

endmodule
`default_nettype wire
